// File: rtl/sdr_qsram_pkg.sv
// Shared types and helpers for the SDR synchronous SRAM controller.
// The optional parity feature is selected with SDR_QSRAM_PARITY_EN.
package sdr_qsram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEPTH              = 2**DEFAULT_ADDR_WIDTH;
    localparam int PARITY_MAX_WIDTH   = 64;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        REFRESH = 1'b1
    } state_e;

    // Even parity: returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/sdr_qsram_refresh_timer.sv
// Free-running refresh interval counter with a coalescing pending flag.
module sdr_qsram_refresh_timer
#(
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic refresh_req,
    input  logic refresh_ack,
    output logic refresh_pending,
    output logic refresh_pending_next
);

    localparam int CW = $clog2(REFRESH_INTERVAL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pending_q;
    logic          pending_d;
    logic          wrap;

    // Next counter value and pending flag; a new request wins over the ack.
    always_comb begin
        wrap = (cnt_q == CW'(REFRESH_INTERVAL - 1));
        if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (wrap || refresh_req) begin
            pending_d = 1'b1;
        end else if (refresh_ack) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Counter and pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign refresh_pending      = pending_q;
    assign refresh_pending_next = pending_d;

endmodule

// File: rtl/sdr_qsram_ctrl.sv
// SDR synchronous SRAM controller: pipelined reads, refresh scheduling.
// Define SDR_QSRAM_PARITY_EN to add per-word even parity (ParityInject/ParityError).
module sdr_qsram_ctrl
    import sdr_qsram_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH       = 8,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Refresh,
`ifdef SDR_QSRAM_PARITY_EN
    input  logic                  ParityInject,
    output logic                  ParityError,
`endif
    output logic                  Ready,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  RefreshBusy,
    output logic [ADDR_WIDTH-1:0] RefreshRow
);

    localparam int MEM_DEPTH = 2**ADDR_WIDTH;
`ifdef SDR_QSRAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam int BW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [MEM_W-1:0]        mem [MEM_DEPTH];
    logic [MEM_W-1:0]        wr_word;
    logic [MEM_W-1:0]        rd_word;
    logic [MEM_W-1:0]        rd_entry;

    state_e                  state_q, state_d;
    logic [BW-1:0]           busy_cnt_q, busy_cnt_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [MEM_W-1:0]        pipe_data_q [READ_LATENCY];
    logic [MEM_W-1:0]        pipe_data_d [READ_LATENCY];

    logic refresh_pending;
    logic refresh_pending_next;
    logic refresh_ack;
    logic accept;
    logic wr_accept;
    logic rd_accept;

    assign accept    = Enable & ready_q & (Read | Write);
    assign wr_accept = accept & Write;
    assign rd_accept = accept & Read & ~Write;
    assign rd_word   = mem[Address];

`ifdef SDR_QSRAM_PARITY_EN
    assign wr_word  = {even_parity(PARITY_MAX_WIDTH'(WriteData)) ^ ParityInject, WriteData};
    // Pipeline carries the mismatch flag in place of the raw stored parity bit.
    assign rd_entry = {even_parity(PARITY_MAX_WIDTH'(rd_word[DATA_WIDTH-1:0])) ^ rd_word[DATA_WIDTH],
                       rd_word[DATA_WIDTH-1:0]};
`else
    assign wr_word  = WriteData;
    assign rd_entry = rd_word;
`endif

    sdr_qsram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk                  (Clock),
        .reset                (Reset),
        .refresh_req          (Refresh),
        .refresh_ack          (refresh_ack),
        .refresh_pending      (refresh_pending),
        .refresh_pending_next (refresh_pending_next)
    );

    // Storage array; contents deliberately survive Reset.
    always_ff @(posedge Clock) begin
        if (wr_accept) begin
            mem[Address] <= wr_word;
        end
    end

    // Refresh FSM next state, row advance, and registered Ready/RefreshBusy.
    always_comb begin
        state_d     = state_q;
        busy_cnt_d  = busy_cnt_q;
        row_d       = row_q;
        refresh_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (refresh_pending) begin
                    state_d     = REFRESH;
                    busy_cnt_d  = '0;
                    row_d       = row_q + ADDR_WIDTH'(1);
                    refresh_ack = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REFRESH: begin
                if (busy_cnt_q == BW'(REFRESH_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Ready is precomputed so it already drops in the cycle pending becomes visible.
        ready_d = (state_d == IDLE) & ~refresh_pending_next;
        busy_d  = (state_d == REFRESH);
    end

    // Read pipeline shift with per-stage valid bits.
    always_comb begin
        pipe_valid_d[0] = rd_accept;
        pipe_data_d[0]  = rd_entry;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
    end

    // State, output and pipeline registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            busy_cnt_q   <= '0;
            row_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            pipe_valid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_cnt_q   <= busy_cnt_d;
            row_q        <= row_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

    assign Ready       = ready_q;
    assign ReadValid   = pipe_valid_q[READ_LATENCY-1];
    assign ReadData    = pipe_data_q[READ_LATENCY-1][DATA_WIDTH-1:0];
    assign RefreshBusy = busy_q;
    assign RefreshRow  = row_q;
`ifdef SDR_QSRAM_PARITY_EN
    assign ParityError = pipe_valid_q[READ_LATENCY-1] & pipe_data_q[READ_LATENCY-1][DATA_WIDTH];
`endif

endmodule

// File: tb/tb_sdr_qsram_ctrl.sv
// Scoreboard bench for sdr_qsram_ctrl: directed refresh/reset cases plus random traffic.
module tb_sdr_qsram_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RL = 2;
    localparam int RI = 64;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          Reset, Enable, Read, Write, Refresh;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic          Ready, ReadValid, RefreshBusy;
    logic [DW-1:0] ReadData;
    logic [AW-1:0] RefreshRow;
`ifdef SDR_QSRAM_PARITY_EN
    logic          ParityInject, ParityError;
`endif

    sdr_qsram_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
        .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .Clock(clk), .Reset(Reset), .Enable(Enable), .Read(Read), .Write(Write),
        .Address(Address), .WriteData(WriteData), .Refresh(Refresh),
`ifdef SDR_QSRAM_PARITY_EN
        .ParityInject(ParityInject), .ParityError(ParityError),
`endif
        .Ready(Ready), .ReadData(ReadData), .ReadValid(ReadValid),
        .RefreshBusy(RefreshBusy), .RefreshRow(RefreshRow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdata [2**AW];
    logic          mperr [2**AW];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            run = 0;
    int            max_run = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ReadValid must match the oldest expected read, on its due cycle.
    initial begin
        exp_t e;
        logic perr_act;
        forever begin
            @(negedge clk);
            if (ReadValid === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_readvalid: got data %0h, expected no ReadValid (cycle %0d)",
                             ReadData, cyc);
                end else begin
                    e = sb.pop_front();
`ifdef SDR_QSRAM_PARITY_EN
                    perr_act = ParityError;
`else
                    perr_act = e.perr;
`endif
                    if (ReadData !== e.data || cyc != e.due || perr_act !== e.perr) begin
                        errors++;
                        $display("FAIL read_data: got %0h perr %0b at cycle %0d, expected %0h perr %0b at cycle %0d",
                                 ReadData, perr_act, cyc, e.data, e.perr, e.due);
                    end
                end
            end else begin
                run = 0;
                if (sb.size() > 0 && cyc >= sb[0].due) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_readvalid: got none at cycle %0d, expected data %0h",
                             cyc, sb[0].data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Present one request at a negedge, hold it until Ready, update the model on accept.
    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic inj);
        int tries = 0;
        exp_t e;
        Enable = 1'b1; Read = rd; Write = wr; Address = a; WriteData = d;
`ifdef SDR_QSRAM_PARITY_EN
        ParityInject = inj;
`endif
        while (Ready !== 1'b1 && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (Ready !== 1'b1) begin
            chk("accept_timeout", 32'(Ready), 32'd1);
        end else begin
            if (wr) begin
                mdata[a] = d;
                mperr[a] = inj;
            end else if (rd) begin
                e.data = mdata[a];
                e.perr = mperr[a];
                e.due  = cyc + RL;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        Enable = 1'b0; Read = 1'b0; Write = 1'b0;
`ifdef SDR_QSRAM_PARITY_EN
        ParityInject = 1'b0;
`endif
    endtask

    task automatic wait_busy(output int rel, input int c0);
        int n = 0;
        while (RefreshBusy !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        rel = cyc - c0;
        chk("busy_timeout", 32'(RefreshBusy), 32'd1);
    endtask

    initial begin
        int c0, rel, n, g;
        logic [AW-1:0] row_start;
        Reset = 1'b1; Enable = 1'b0; Read = 1'b0; Write = 1'b0; Refresh = 1'b0;
        Address = '0; WriteData = '0;
`ifdef SDR_QSRAM_PARITY_EN
        ParityInject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(Ready), 32'd0);
        chk("reset_readvalid", 32'(ReadValid), 32'd0);
        chk("reset_busy", 32'(RefreshBusy), 32'd0);
        chk("reset_row", 32'(RefreshRow), 32'd0);
        chk("reset_readdata", 32'(ReadData), 32'd0);

        // Idle refresh: pending after RI cycles, REFRESH the cycle after; requests ignored.
        Reset = 1'b0;
        c0 = cyc;
        n = 0;
        while (RefreshBusy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (cyc - c0 == 1) chk("ready_after_reset", 32'(Ready), 32'd1);
            if (cyc - c0 == RI) begin
                chk("ready_low_pending", 32'(Ready), 32'd0);
                Enable = 1'b1; Read = 1'b1; Address = 4'd9;
            end
        end
        chk("first_refresh_cycle", 32'(cyc - c0), 32'(RI + 1));
        n = 0;
        while (RefreshBusy === 1'b1 && n < 20) begin
            chk("ready_low_busy", 32'(Ready), 32'd0);
            n++;
            @(negedge clk);
        end
        Enable = 1'b0; Read = 1'b0;
        chk("busy_length", 32'(n), 32'(RC));
        chk("row_after_first", 32'(RefreshRow), 32'd1);

        // Refresh pulse during REFRESH: one IDLE cycle, then a second REFRESH.
        wait_busy(rel, c0);
        row_start = RefreshRow;
        chk("row_second", 32'(row_start), 32'd2);
        @(negedge clk);
        Refresh = 1'b1;
        @(negedge clk);
        Refresh = 1'b0;
        n = 0;
        while (RefreshBusy === 1'b1 && n < 20) begin @(negedge clk); n++; end
        g = 0;
        while (RefreshBusy !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        chk("idle_gap", 32'(g), 32'd1);
        n = 0;
        while (RefreshBusy === 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("busy_length_2", 32'(n), 32'(RC));
        chk("row_twice", 32'(RefreshRow), 32'(row_start + 4'd1));

        // Reset the cycle after a read accept flushes it.
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        Enable = 1'b1; Read = 1'b1; Address = 4'd5;
        chk("ready_before_midread", 32'(Ready), 32'd1);
        @(negedge clk);
        Enable = 1'b0; Read = 1'b0; Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("ready_low_after_reset", 32'(Ready), 32'd0);
        for (int i = 0; i < RL + 2; i++) begin
            chk("flushed_readvalid", 32'(ReadValid), 32'd0);
            if (i == 0) chk("row_cleared", 32'(RefreshRow), 32'd0);
            @(negedge clk);
            if (i == 0) chk("ready_one_after_reset", 32'(Ready), 32'd1);
        end

        // Fill, write-then-read, read&write, back-to-back reads.
        for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 4'(i), 8'(i), 1'b0);
        issue(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0);
        issue(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        issue(1'b1, 1'b1, 4'd7, 8'h5A, 1'b0);
        max_run = 0;
        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
        repeat (RL + 1) @(negedge clk);
        chk("back_to_back_run", 32'(max_run >= 16), 32'd1);

`ifdef SDR_QSRAM_PARITY_EN
        issue(1'b0, 1'b1, 4'd2, 8'h3C, 1'b1);
        issue(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        issue(1'b0, 1'b1, 4'd2, 8'h3C, 1'b0);
        issue(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
`endif

        // Random traffic, including refresh stalls and ignored requests.
        for (int k = 0; k < 400; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                issue(1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'h00, 1'b0);
            end else if (op <= 6) begin
                issue(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
            end else if (op == 7) begin
                issue(1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0);
            end else if (op == 8) begin
                Enable = 1'b1; Address = 4'($urandom_range(0, 15));
                @(negedge clk);
                Enable = 1'b0;
            end else begin
                Refresh = 1'($urandom_range(0, 3) == 0);
                @(negedge clk);
                Refresh = 1'b0;
            end
        end

        repeat (RL + 3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
